// File: rtl/mc_alu_sequencer.sv
// Multi-cycle main control FSM for the RV64 integer core: decodes the IR and
// sequences the shared ALU, datapath strobes and memory handshake.
module mc_alu_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        z,
  input  logic        mem_ready,
  output logic [2:0]  alu_op,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_size,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [3:0]  state_dbg
);

  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] DECODE    = 4'd1;
  localparam logic [3:0] EXEC_R    = 4'd2;
  localparam logic [3:0] EXEC_I    = 4'd3;
  localparam logic [3:0] EXEC_BR   = 4'd4;
  localparam logic [3:0] EXEC_JAL  = 4'd5;
  localparam logic [3:0] EXEC_JALR = 4'd6;
  localparam logic [3:0] ADDR      = 4'd7;
  localparam logic [3:0] MEM_RD    = 4'd8;
  localparam logic [3:0] MEM_WR    = 4'd9;
  localparam logic [3:0] WB_ALU    = 4'd10;
  localparam logic [3:0] WB_MEM    = 4'd11;
  localparam logic [3:0] TRAP      = 4'd12;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;

  localparam logic [1:0] CAUSE_ILL = 2'b01;
  localparam logic [1:0] CAUSE_TMO = 2'b10;

  // Last wait-counter value before the limit; only used when the timeout is enabled.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [3:0]       state;
  logic [3:0]       next;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cause_n;
  logic             timeout;
  logic             wait_st;
  logic             pcw, irw, mrd, mwr, rwe, ret;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign rd            = instr[11:7];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^instr[24:15];

  function automatic logic logic_f3_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b111, 3'b110, 3'b100, 3'b010: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [2:0] logic_f3_op(input logic [2:0] f3);
    logic [2:0] op;
    case (f3)
      3'b111:  op = OP_AND;
      3'b110:  op = OP_OR;
      3'b100:  op = OP_XOR;
      3'b010:  op = OP_SLT;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

  function automatic logic load_f3_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b011, 3'b010, 3'b110, 3'b001, 3'b101: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic store_f3_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b011, 3'b010, 3'b001: ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign wait_st = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  // mem_ready on the limit cycle takes priority over the timeout.
  assign timeout = (MEM_TIMEOUT != 0) && (cnt == TO_LAST) && !mem_ready;

  // Next-state and Moore output decode of the state register and IR fields.
  always_comb begin
    next      = state;
    cause_n   = 2'b00;
    alu_op    = OP_ADD;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    pc_src    = 2'b00;
    wb_sel    = 2'b00;
    iord      = 1'b0;
    mem_size  = 3'b010;
    pcw       = 1'b0;
    irw       = 1'b0;
    mrd       = 1'b0;
    mwr       = 1'b0;
    rwe       = 1'b0;
    ret       = 1'b0;
    case (state)
      FETCH: begin
        mrd       = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          irw  = 1'b1;
          pcw  = 1'b1;
          next = DECODE;
        end else if (timeout) begin
          next    = TRAP;
          cause_n = CAUSE_TMO;
        end else begin
          next = FETCH;
        end
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        case (opcode)
          7'b0110011: next = EXEC_R;
          7'b0010011: next = EXEC_I;
          7'b1100011: next = EXEC_BR;
          7'b1101111: next = EXEC_JAL;
          7'b1100111: next = EXEC_JALR;
          7'b0000011,
          7'b0100011: next = ADDR;
          default: begin
            next    = TRAP;
            cause_n = CAUSE_ILL;
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        if ((funct7 != 7'b0000000) && (funct7 != 7'b0100000)) begin
          next    = TRAP;
          cause_n = CAUSE_ILL;
        end else if (funct3 == 3'b000) begin
          alu_op = (funct7 == 7'b0100000) ? OP_SUB : OP_ADD;
          next   = WB_ALU;
        end else if (logic_f3_legal(funct3)) begin
          alu_op = logic_f3_op(funct3);
          next   = WB_ALU;
        end else begin
          next    = TRAP;
          cause_n = CAUSE_ILL;
        end
      end
      EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        if (funct3 == 3'b000) begin
          alu_op = OP_ADDI;
          next   = WB_ALU;
        end else if (logic_f3_legal(funct3)) begin
          alu_op = logic_f3_op(funct3);
          next   = WB_ALU;
        end else begin
          next    = TRAP;
          cause_n = CAUSE_ILL;
        end
      end
      EXEC_BR: begin
        alu_op    = OP_SUB;
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        pc_src    = 2'b01;
        if (funct3 == 3'b001) begin
          pcw  = ~z;
          ret  = 1'b1;
          next = FETCH;
        end else begin
          next    = TRAP;
          cause_n = CAUSE_ILL;
        end
      end
      EXEC_JAL: begin
        wb_sel = 2'b10;
        pc_src = 2'b01;
        rwe    = (rd != 5'd0);
        pcw    = 1'b1;
        ret    = 1'b1;
        next   = FETCH;
      end
      EXEC_JALR: begin
        alu_op    = OP_ADDI;
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        pc_src    = 2'b10;
        wb_sel    = 2'b10;
        rwe       = (rd != 5'd0);
        pcw       = 1'b1;
        ret       = 1'b1;
        next      = FETCH;
      end
      ADDR: begin
        alu_op    = OP_ADDI;
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        if ((opcode == 7'b0000011) && load_f3_legal(funct3)) begin
          next = MEM_RD;
        end else if ((opcode == 7'b0100011) && store_f3_legal(funct3)) begin
          next = MEM_WR;
        end else begin
          next    = TRAP;
          cause_n = CAUSE_ILL;
        end
      end
      MEM_RD: begin
        iord     = 1'b1;
        mem_size = funct3;
        mrd      = 1'b1;
        if (mem_ready) begin
          next = WB_MEM;
        end else if (timeout) begin
          next    = TRAP;
          cause_n = CAUSE_TMO;
        end else begin
          next = MEM_RD;
        end
      end
      MEM_WR: begin
        iord     = 1'b1;
        mem_size = funct3;
        mwr      = 1'b1;
        if (mem_ready) begin
          ret  = 1'b1;
          next = FETCH;
        end else if (timeout) begin
          next    = TRAP;
          cause_n = CAUSE_TMO;
        end else begin
          next = MEM_WR;
        end
      end
      WB_ALU: begin
        wb_sel = 2'b00;
        rwe    = (rd != 5'd0);
        ret    = 1'b1;
        next   = FETCH;
      end
      WB_MEM: begin
        wb_sel = 2'b01;
        rwe    = (rd != 5'd0);
        ret    = 1'b1;
        next   = FETCH;
      end
      TRAP: begin
        next = TRAP;
      end
      default: begin
        next    = TRAP;
        cause_n = CAUSE_ILL;
      end
    endcase
  end

  // Strobes are held low for as long as reset is asserted.
  assign pc_write  = pcw & rst_n;
  assign ir_write  = irw & rst_n;
  assign mem_read  = mrd & rst_n;
  assign mem_write = mwr & rst_n;
  assign reg_write = rwe & rst_n;
  assign retire    = ret & rst_n;
  assign state_dbg = state;

  // State register, wait counter and sticky trap status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FETCH;
      cnt        <= '0;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
    end else begin
      state <= next;
      if ((next != state) || !wait_st) begin
        cnt <= '0;
      end else if (!mem_ready) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= cnt;
      end
      if ((state != TRAP) && (next == TRAP)) begin
        trap       <= 1'b1;
        trap_cause <= cause_n;
      end else begin
        trap       <= trap;
        trap_cause <= trap_cause;
      end
    end
  end

endmodule

// File: doc/mc_alu_sequencer.md
Name: mc_alu_sequencer

Overview:
- Multi-cycle main control FSM for the RV64 integer core.
- Decodes the latched instruction register and sequences the shared 64-bit ALU across fetch, decode, execute, memory and writeback.
- Drives ALU op and operand selects, PC/IR/register-file/memory strobes, and the memory request handshake.
- Detects illegal encodings and memory timeouts and halts in a sticky trap state.

Parameters:
- MEM_TIMEOUT, 255: max cycles a memory request waits for mem_ready before trapping; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- instr  in  32  instruction register contents; stable from DECODE until the next FETCH.
- z  in  1  ALU zero flag, from the current-cycle ALU result.
- mem_ready  in  1  memory completion for the request asserted this cycle.
- alu_op  out  3  ADD=000, SUB=001, AND=010, OR=011, XOR=100, SLT=101, ADDI=110.
- alu_src_a  out  2  00=PC, 01=OLD_PC, 10=rs1 register A.
- alu_src_b  out  2  00=rs2 register B, 01=const 4, 10=immediate.
- pc_write  out  1  load PC this cycle.
- pc_src  out  2  00=ALU result, 01=ALUOUT register, 10=ALU result with bit0 cleared.
- ir_write  out  1  load IR and OLD_PC.
- iord  out  1  memory address from 0=PC, 1=ALUOUT.
- mem_read  out  1  read request; held until mem_ready.
- mem_write  out  1  write request; held until mem_ready.
- mem_size  out  3  instr[14:12] during data accesses, else 010.
- reg_write  out  1  register-file write enable.
- wb_sel  out  2  00=ALUOUT, 01=MDR, 10=PC.
- retire  out  1  one-cycle pulse on the cycle an instruction completes.
- trap  out  1  sticky halt indicator.
- trap_cause  out  2  00=none, 01=illegal instruction, 10=memory timeout.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset:
  - While rst_n=0 at a clock edge: state <= FETCH, wait counter <= 0, trap <= 0, trap_cause <= 00.
  - While rst_n=0, all strobes are forced 0: pc_write, ir_write, mem_read, mem_write, reg_write, retire.
  - A reset during a pending memory wait abandons the request; there is no deferred completion.
- Outputs are Moore decodes of the state register plus IR fields. Exceptions: branch pc_write uses z, and exits use mem_ready, both combinationally.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=PC, alu_src_b=4, alu_op=ADD, pc_src=00.
  - On mem_ready: ir_write=1 and pc_write=1 in the same cycle, then go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - alu_src_a=OLD_PC, alu_src_b=imm, ADD; the datapath latches ALUOUT as the branch/JAL target.
  - Next state by opcode: 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> EXEC_BR; 1101111 -> EXEC_JAL; 1100111 -> EXEC_JALR; 0000011 or 0100011 -> ADDR.
  - Any other opcode -> TRAP with cause 01.
- EXEC_R:
  - Decode by funct3: 000 -> ADD, or SUB if funct7=0100000; 111 -> AND; 110 -> OR; 100 -> XOR; 010 -> SLT.
  - Any other funct3, or funct7 not in {0000000, 0100000} -> TRAP with cause 01.
  - Operands rs1/rs2; next state WB_ALU.
- EXEC_I: funct3 000 -> ADDI; 111/110/100/010 as in EXEC_R; others -> TRAP. Operands rs1/imm; next state WB_ALU.
- EXEC_BR:
  - Only funct3=001 (BNE) is legal; others -> TRAP.
  - alu_op=SUB on rs1/rs2; pc_write=~z with pc_src=01; retire; next state FETCH.
- EXEC_JAL: reg_write (wb_sel=PC), pc_write with pc_src=01, retire, next state FETCH.
- EXEC_JALR: ADDI on rs1/imm, pc_src=10, pc_write, reg_write (wb_sel=PC), retire, next state FETCH.
- ADDR:
  - ADDI on rs1/imm.
  - Load funct3 must be in {011, 010, 110, 001, 101}; store funct3 must be in {011, 010, 001}; otherwise TRAP.
  - Next state MEM_RD for loads, MEM_WR for stores.
- MEM_RD / MEM_WR:
  - iord=1, mem_size=funct3, request held until mem_ready.
  - On mem_ready: MEM_RD -> WB_MEM; MEM_WR -> retire, then FETCH.
- WB_ALU / WB_MEM: reg_write with wb_sel 00 or 01 respectively, retire, next state FETCH.
- rd=0: reg_write is suppressed in every state; retire is unaffected.
- Wait counter (FETCH, MEM_RD, MEM_WR):
  - Clears on state entry and increments each cycle without mem_ready.
  - If MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT with no mem_ready -> TRAP with cause 10.
  - mem_ready arriving on the limit cycle wins over the timeout.
- TRAP: all strobes 0, trap=1, cause held; exit only via reset.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3), mem_ready always 1 -> FETCH, DECODE, EXEC_R (alu_op=000), WB_ALU with reg_write=1; retire at cycle 4; next FETCH at cycle 5.
- BNE (funct3=001) with z=0 -> pc_write=1, pc_src=01 in EXEC_BR; repeat with z=1 -> pc_write=0; both take 3 cycles and pulse retire.
- LW (funct3=010) with mem_ready delayed 3 cycles in MEM_RD -> mem_read and iord=1 held 4 cycles, mem_size=010, then WB_MEM with wb_sel=01; 8 cycles total.
- Opcode 0x7F, or R-type funct7=0000001 -> TRAP from DECODE/EXEC_R; trap=1, cause=01, no strobes; after rst_n low for 1 edge, state_dbg=FETCH.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP with cause 10 after 4 wait cycles; separate run with mem_ready on the 4th cycle -> DECODE, no trap.
- ADDI x0,x1,5 -> reg_write stays 0 in WB_ALU, retire=1; rst_n dropped mid-MEM_WR -> mem_write=0 next cycle, state FETCH.
